// File: rtl/jtpopeye_pkg.sv
// Shared jtpopeye definitions: sync decoder FSM states, default timing
// parameters and counter widths.
package jtpopeye_pkg;

  localparam int VTHR_DEF   = 48;
  localparam int HMAX_DEF   = 511;
  localparam int LOCK_N_DEF = 4;

  localparam int CNT_W = 9;
  localparam int PW_W  = 8;
  localparam logic [PW_W-1:0] PW_MAX = 8'd255;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } csync_state_e;

  // Pulse-width increment that sticks at the top of its range
  function automatic logic [PW_W-1:0] pwSatInc(input logic [PW_W-1:0] v);
    return (v == PW_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/jtpopeye_sync_pulse.sv
// Composite-sync front end: synchronises SY_n, measures each low pulse and
// regenerates HS/VS from the pulse width.
module jtpopeye_sync_pulse
  import jtpopeye_pkg::*;
#(
  parameter int VTHR = VTHR_DEF
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic cen_i,
  input  logic sy_n_i,
  input  logic clr_i,
  output logic fall_o,
  output logic long_o,
  output logic hs_o,
  output logic vs_o
);

  localparam logic [PW_W-1:0] VTHR_W = PW_W'(VTHR);

  logic s1_q, s2_q, sy_q;
  logic prevLong_q, hs_q, vs_q;
  logic [PW_W-1:0] pw_q;
  logic [PW_W-1:0] pwInc;
  logic rise, pulseLong;

  // Edges are taken on the cen-sampled copy so they last exactly one tick
  assign fall_o    = cen_i & sy_q & ~s2_q;
  assign rise      = cen_i & ~sy_q & s2_q;
  assign pwInc     = pwSatInc(pw_q);
  assign pulseLong = (pwInc >= VTHR_W);

  assign long_o = prevLong_q;
  assign hs_o   = hs_q;
  assign vs_o   = vs_q;

  // Two-flop synchroniser running on every clk, idle level high
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= sy_n_i;
      s2_q <= s1_q;
    end
  end

  // Pixel-rate sampling, pulse width measurement and HS/VS regeneration
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sy_q       <= 1'b1;
      pw_q       <= '0;
      prevLong_q <= 1'b0;
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
    end else if (cen_i) begin
      sy_q <= s2_q;
      if (fall_o) begin
        pw_q <= '0;
      end else if (!sy_q) begin
        pw_q <= pwInc;
      end
      if (rise) begin
        prevLong_q <= pulseLong;
      end
      hs_q <= ~clr_i & ~sy_q & (pwInc < VTHR_W);
      if (clr_i) begin
        vs_q <= 1'b0;
      end else if (!sy_q && pwInc == VTHR_W) begin
        vs_q <= 1'b1;
      end else if (rise && !pulseLong) begin
        vs_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/jtpopeye_csync_dec.sv
// Composite sync decoder: measures line periods, counts lines per frame and
// tracks lock onto a stable line period.
module jtpopeye_csync_dec
  import jtpopeye_pkg::*;
#(
  parameter int VTHR   = VTHR_DEF,
  parameter int HMAX   = HMAX_DEF,
  parameter int LOCK_N = LOCK_N_DEF
) (
  input  logic             rst_n,
  input  logic             clk,
  input  logic             pxl_cen,
  input  logic             SY_n,
  output logic             HS,
  output logic             VS,
  output logic [CNT_W-1:0] hcnt,
  output logic [CNT_W-1:0] vcnt,
  output logic [CNT_W-1:0] line_len,
  output logic [CNT_W-1:0] frame_lines,
  output logic             locked
);

  localparam logic [CNT_W-1:0] HMAX_W   = CNT_W'(HMAX);
  localparam logic [7:0]       LOCK_TGT = 8'(LOCK_N - 1);

  csync_state_e     state_q;
  logic [CNT_W-1:0] hcnt_q, vcnt_q, lineLen_q, frameLines_q;
  logic [7:0]       matchCnt_q;
  logic [7:0]       matchNext;
  logic             missCnt_q;
  logic             locked_q;
  logic             syFall, prevLong, timeout, skip, periodMatch;
  logic [CNT_W:0]   period;

  jtpopeye_sync_pulse #(.VTHR(VTHR)) u_pulse (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .cen_i   (pxl_cen),
    .sy_n_i  (SY_n),
    .clr_i   (timeout),
    .fall_o  (syFall),
    .long_o  (prevLong),
    .hs_o    (HS),
    .vs_o    (VS)
  );

  // A fall on the same tick as the ceiling wins over the timeout
  assign timeout     = pxl_cen & ~syFall & (hcnt_q == HMAX_W);
  assign period      = {1'b0, hcnt_q} + 10'd1;
  assign periodMatch = (period == {1'b0, lineLen_q});
  assign skip        = VS | prevLong;
  assign matchNext   = matchCnt_q + 8'd1;

  assign hcnt        = hcnt_q;
  assign vcnt        = vcnt_q;
  assign line_len    = lineLen_q;
  assign frame_lines = frameLines_q;
  assign locked      = locked_q;

  // Ticks since the last sync fall, parked at the ceiling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q <= '0;
    end else if (pxl_cen) begin
      if (syFall) begin
        hcnt_q <= '0;
      end else if (hcnt_q != HMAX_W) begin
        hcnt_q <= hcnt_q + 9'd1;
      end
    end
  end

  // Line counter; the first fall after a vertical pulse starts a new frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vcnt_q       <= '0;
      frameLines_q <= '0;
    end else if (syFall) begin
      if (prevLong) begin
        frameLines_q <= vcnt_q + 9'd1;
        vcnt_q       <= '0;
      end else begin
        vcnt_q <= vcnt_q + 9'd1;
      end
    end
  end

  // Lock FSM: learns the line period and tolerates a single odd line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SEARCH;
      matchCnt_q <= '0;
      missCnt_q  <= 1'b0;
      lineLen_q  <= '0;
      locked_q   <= 1'b0;
    end else if (syFall) begin
      case (state_q)
        SEARCH: begin
          state_q    <= TRACK;
          matchCnt_q <= '0;
          missCnt_q  <= 1'b0;
        end
        TRACK: begin
          if (!skip) begin
            if (periodMatch) begin
              if (matchNext >= LOCK_TGT) begin
                state_q    <= LOCKED;
                locked_q   <= 1'b1;
                matchCnt_q <= '0;
                missCnt_q  <= 1'b0;
              end else begin
                matchCnt_q <= matchNext;
              end
            end else begin
              lineLen_q  <= period[CNT_W-1:0];
              matchCnt_q <= '0;
            end
          end
        end
        LOCKED: begin
          if (!skip) begin
            if (periodMatch) begin
              missCnt_q <= 1'b0;
            end else if (missCnt_q) begin
              state_q    <= TRACK;
              locked_q   <= 1'b0;
              lineLen_q  <= period[CNT_W-1:0];
              missCnt_q  <= 1'b0;
              matchCnt_q <= '0;
            end else begin
              missCnt_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q  <= SEARCH;
          locked_q <= 1'b0;
        end
      endcase
    end else if (timeout) begin
      state_q    <= SEARCH;
      locked_q   <= 1'b0;
      matchCnt_q <= '0;
      missCnt_q  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtpopeye_csync_dec.sv
// Bench for the composite sync decoder: timestamp-based reference model
// compared every clock plus literal checkpoints for the key scenarios.
module tb_jtpopeye_csync_dec;
  import jtpopeye_pkg::*;

  localparam int VTHR   = VTHR_DEF;
  localparam int HMAX   = HMAX_DEF;
  localparam int LOCK_N = LOCK_N_DEF;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pxl_cen;
  logic       SY_n;
  logic       HS, VS, locked;
  logic [8:0] hcnt, vcnt, line_len, frame_lines;

  int nAssert = 0;
  int nFail   = 0;
  int div     = 1;
  int hsCount = 0;
  bit checkEn = 1'b0;

  always #5 clk = ~clk;

  jtpopeye_csync_dec #(.VTHR(VTHR), .HMAX(HMAX), .LOCK_N(LOCK_N)) dut (
    .rst_n       (rst_n),
    .clk         (clk),
    .pxl_cen     (pxl_cen),
    .SY_n        (SY_n),
    .HS          (HS),
    .VS          (VS),
    .hcnt        (hcnt),
    .vcnt        (vcnt),
    .line_len    (line_len),
    .frame_lines (frame_lines),
    .locked      (locked)
  );

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    nAssert++;
    if (actual != expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: everything is derived from tick timestamps of the
  // last sync fall, the pulse width so far and an integer lock mode
  bit mS1 = 1, mS2 = 1, mSy = 1, mHs = 0, mVs = 0, mLocked = 0, mPrevLong = 0;
  int mTick = 0, mLastFall = 0, mState = 0, mMatch = 0, mMiss = 0;
  int mLineLen = 0, mVcnt = 0, mFrame = 0, mHcnt = 0;
  bit newSy, isFall, isRise, isTimeout, skip, match;
  int since, hBefore, lowAge, period;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mS1 = 1; mS2 = 1; mSy = 1; mHs = 0; mVs = 0; mLocked = 0; mPrevLong = 0;
      mTick = 0; mLastFall = 0; mState = 0; mMatch = 0; mMiss = 0;
      mLineLen = 0; mVcnt = 0; mFrame = 0; mHcnt = 0;
    end else begin
      if (pxl_cen) begin
        newSy     = mS2;
        mTick++;
        since     = mTick - mLastFall;
        hBefore   = imin(since - 1, HMAX);
        isFall    = mSy && !newSy;
        isRise    = !mSy && newSy;
        isTimeout = !isFall && (hBefore == HMAX);
        lowAge    = imin(since, 255);
        period    = hBefore + 1;
        skip      = mVs || mPrevLong;
        match     = (period == mLineLen);
        if (isFall) begin
          if (mState == 0) begin
            mState = 1; mMatch = 0; mMiss = 0;
          end else if (!skip) begin
            if (mState == 1) begin
              if (match) begin
                mMatch++;
                if (mMatch >= LOCK_N - 1) begin
                  mState = 2; mMatch = 0; mMiss = 0;
                end
              end else begin
                mLineLen = period % 512; mMatch = 0;
              end
            end else begin
              if (match) mMiss = 0;
              else begin
                mMiss++;
                if (mMiss == 2) begin
                  mState = 1; mLineLen = period % 512; mMiss = 0; mMatch = 0;
                end
              end
            end
          end
          if (mPrevLong) begin
            mFrame = (mVcnt + 1) % 512; mVcnt = 0;
          end else begin
            mVcnt = (mVcnt + 1) % 512;
          end
          mLastFall = mTick;
        end else if (isTimeout) begin
          mState = 0; mMatch = 0; mMiss = 0;
        end
        mLocked = (mState == 2);
        mHcnt   = isFall ? 0 : imin(since, HMAX);
        mHs     = !isTimeout && !mSy && (lowAge < VTHR);
        if (isTimeout) mVs = 0;
        else if (!mSy && lowAge == VTHR) mVs = 1;
        else if (isRise && lowAge < VTHR) mVs = 0;
        if (isRise) mPrevLong = (lowAge >= VTHR);
        mSy = newSy;
      end
      mS2 = mS1;
      mS1 = SY_n;
    end
  end

  // Every-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    if (checkEn) begin
      if (HS === 1'b1) hsCount++;
      checkOutput("HS", int'(HS), int'(mHs));
      checkOutput("VS", int'(VS), int'(mVs));
      checkOutput("hcnt", int'(hcnt), mHcnt);
      checkOutput("vcnt", int'(vcnt), mVcnt);
      checkOutput("line_len", int'(line_len), mLineLen);
      checkOutput("frame_lines", int'(frame_lines), mFrame);
      checkOutput("locked", int'(locked), int'(mLocked));
    end
  end

  task automatic driveTick(input logic v);
    for (int k = 0; k < div; k++) begin
      SY_n    = v;
      pxl_cen = (k == div - 1);
      @(negedge clk);
    end
  endtask

  // One line: lowLen ticks of sync low, then high until the period ends
  task automatic applyStimulus(input int per, input int lowLen);
    for (int t = 0; t < per; t++) driveTick((t < lowLen) ? 1'b0 : 1'b1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "[TB] watchdog expired");
  end

  int hsBefore;
  int longP, lowL;

  initial begin
    rst_n = 1'b0; SY_n = 1'b1; pxl_cen = 1'b0;
    repeat (3) @(negedge clk);
    checkEn = 1'b1;
    @(negedge clk);
    checkOutput("rst_hcnt", int'(hcnt), 0);
    checkOutput("rst_locked", int'(locked), 0);
    checkOutput("rst_line_len", int'(line_len), 0);
    rst_n = 1'b1;

    // Steady 384-tick lines: lock on the fifth fall (fourth equal period)
    for (int i = 0; i < 4; i++) applyStimulus(384, 32);
    checkOutput("not_locked_yet", int'(locked), 0);
    applyStimulus(384, 32);
    checkOutput("locked_5th", int'(locked), 1);
    checkOutput("line_len_384", int'(line_len), 384);
    checkOutput("model_line_len", mLineLen, 384);
    applyStimulus(384, 32);
    hsBefore = hsCount;
    applyStimulus(384, 32);
    checkOutput("hs_width", hsCount - hsBefore, 32);
    for (int i = 0; i < 3; i++) applyStimulus(384, 32);

    // Short lines up to line 239, then a vertical pulse on line 240
    for (int i = 0; i < 229; i++) applyStimulus(64, 16);
    applyStimulus(384, 96);
    checkOutput("vs_high", int'(VS), 1);
    checkOutput("vcnt_240", int'(vcnt), 240);
    applyStimulus(384, 32);
    checkOutput("frame_lines_241", int'(frame_lines), 241);
    checkOutput("model_frame", mFrame, 241);
    checkOutput("vcnt_frame_start", int'(vcnt), 0);
    checkOutput("vs_cleared", int'(VS), 0);

    // Relock, then single and double odd periods
    for (int i = 0; i < 8; i++) applyStimulus(384, 32);
    checkOutput("relocked", int'(locked), 1);
    applyStimulus(380, 32);
    applyStimulus(384, 32);
    checkOutput("one_miss_locked", int'(locked), 1);
    checkOutput("one_miss_len", int'(line_len), 384);
    applyStimulus(384, 32);
    applyStimulus(380, 32);
    applyStimulus(380, 32);
    applyStimulus(384, 32);
    checkOutput("two_miss_unlocked", int'(locked), 0);
    checkOutput("two_miss_len", int'(line_len), 380);

    // Sync stuck high: timeout and saturation, line count frozen
    applyStimulus(600, 0);
    checkOutput("timeout_hcnt", int'(hcnt), 511);
    checkOutput("timeout_locked", int'(locked), 0);
    checkOutput("timeout_vcnt", int'(vcnt), 14);

    // Fall exactly at the ceiling, and pulse-width boundaries
    applyStimulus(300, 20);
    applyStimulus(512, 20);
    applyStimulus(300, 20);
    applyStimulus(200, 47);
    applyStimulus(200, 48);
    applyStimulus(200, 32);
    applyStimulus(400, 300);
    applyStimulus(200, 32);

    // Quarter-rate pixel enable with a mid-line reset while locked
    div = 4;
    for (int i = 0; i < 8; i++) applyStimulus(384, 32);
    checkOutput("q_locked", int'(locked), 1);
    applyStimulus(100, 32);
    #2 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_hcnt", int'(hcnt), 0);
    checkOutput("mid_rst_vcnt", int'(vcnt), 0);
    checkOutput("mid_rst_line_len", int'(line_len), 0);
    checkOutput("mid_rst_frame", int'(frame_lines), 0);
    checkOutput("mid_rst_hs", int'(HS), 0);
    checkOutput("mid_rst_vs", int'(VS), 0);
    checkOutput("mid_rst_locked", int'(locked), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(384, 32);
    checkOutput("q_not_yet", int'(locked), 0);
    applyStimulus(384, 32);
    checkOutput("q_relocked", int'(locked), 1);
    checkOutput("q_line_len", int'(line_len), 384);

    // Randomised lines, enable rates, vertical pulses and timeouts
    for (int i = 0; i < 50; i++) begin
      div = int'($urandom_range(1, 2));
      if ($urandom_range(0, 19) == 0) begin
        applyStimulus(520, 0);
      end else if ($urandom_range(0, 9) == 0) begin
        longP = int'($urandom_range(130, 320));
        lowL  = int'($urandom_range(VTHR, 120));
        applyStimulus(longP, lowL);
      end else begin
        longP = int'($urandom_range(24, 320));
        lowL  = int'($urandom_range(1, imin(40, longP - 1)));
        applyStimulus(longP, lowL);
      end
    end

    checkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/jtpopeye_csync_dec.md
JTPOPEYE_CSYNC_DEC -- requirements
Module: jtpopeye_csync_dec

Interface
REQ-001 Parameter VTHR, default 48: pulse width in pxl_cen ticks at or above which an SY_n low pulse is classified as vertical.
REQ-002 Parameter HMAX, default 511: period ceiling in ticks; reaching it without an SY_n fall is a sync timeout.
REQ-003 Parameter LOCK_N, default 4: consecutive equal line periods required for lock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 clk  input  1  system clock; the only clock.
REQ-006 pxl_cen  input  1  pixel clock enable; all state advances only when high.
REQ-007 SY_n  input  1  composite sync, low-active, asynchronous to clk.
REQ-008 HS  output  1  regenerated horizontal sync, high-active.
REQ-009 VS  output  1  regenerated vertical sync, high-active.
REQ-010 hcnt  output  9  ticks since last SY_n fall.
REQ-011 vcnt  output  9  lines since frame start.
REQ-012 line_len  output  9  last accepted line period in ticks.
REQ-013 frame_lines  output  9  line count of last completed frame.
REQ-014 locked  output  1  high while the FSM is in LOCKED.

Function
REQ-015 SY_n shall pass through a two-flop clk synchroniser, then a pxl_cen-qualified register sy; edges are detected on sy only.
REQ-016 Low-pulse width counter pw: cleared on sy fall, +1 per pxl_cen while sy low, saturating at 255.
REQ-017 On sy rise: pulse is long if pw>=VTHR, otherwise short; classification stored in flag prev_long.
REQ-018 HS shall be high while sy low and pw<VTHR; it falls when pw reaches VTHR (1-tick latency after sy).
REQ-019 VS shall set on the tick pw reaches VTHR and clear on the sy rise ending the first short pulse after it.
REQ-020 On each sy fall: period = hcnt+1; hcnt reset to 0; otherwise hcnt +1 per pxl_cen, saturating at HMAX.
REQ-021 On each sy fall vcnt +1, except on the first fall after a long pulse ends: frame_lines <= vcnt+1, vcnt <= 0.
REQ-022 Period comparison shall be skipped (neither match nor mismatch) when VS is high or prev_long is set.
REQ-023 FSM states SEARCH, TRACK, LOCKED; reset state SEARCH.
REQ-024 SEARCH: first sy fall -> TRACK, match count 0; line_len unchanged.
REQ-025 TRACK: period==line_len increments match count; at LOCK_N-1 matches -> LOCKED; mismatch loads line_len<=period, count<=0.
REQ-026 LOCKED: mismatch increments miss count without updating line_len; 2 consecutive misses -> TRACK with line_len<=period; a match clears miss count.
REQ-027 Timeout (hcnt==HMAX) in any state -> SEARCH, locked low, HS and VS low, vcnt held.
REQ-028 sy fall coinciding with hcnt==HMAX shall be treated as a fall (fall wins over timeout).
REQ-029 pxl_cen low: no register except the synchroniser changes.

Reset
REQ-030 On rst_n low: hcnt=0, vcnt=0, pw=0, line_len=0, frame_lines=0, HS=0, VS=0, locked=0, FSM=SEARCH, counters 0, sy=1; effective mid-operation with no completion of any pending update.

Structure
REQ-031 FSM state encoding and default VTHR/HMAX/LOCK_N shall live in the shared jtpopeye package alongside the timing constants.
REQ-032 Pulse classification (sync, sy, pw, HS/VS) shall be one sub-module jtpopeye_sync_pulse; period/lock/count logic stays in the top.

Verification
REQ-033 Reset, then 10 lines of 384-tick period, 32-tick low pulses -> locked high at 4th equal period, line_len=384, HS high 32 ticks per line.
REQ-034 Insert one 96-tick low pulse after 240 lines -> VS high from pw=48 until first short pulse ends; next frame start gives frame_lines=241, vcnt=0.
REQ-035 While locked, one 380-tick period -> locked stays high, line_len=384; two consecutive 380-tick periods -> TRACK, locked low, line_len=380.
REQ-036 Hold SY_n high for 600 ticks -> at hcnt=511 FSM=SEARCH, locked low, hcnt saturates at 511.
REQ-037 pxl_cen at 1/4 clk, rst_n pulsed low mid-line while locked -> all outputs at reset values next clk; relock after 4 equal periods.
